// File: rtl/mux_scan_reg.sv
// Registered N-channel word multiplexer with enable, wrap-around auto-scan
// and out-of-range select detection. All outputs come straight from flops.
module mux_scan_reg #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH*CHANNELS-1:0] in_bus,
  input  logic [SEL_W-1:0]          set,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          r,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      sel_err
);

  localparam int unsigned LAST_CH = CHANNELS - 1;

  logic [WIDTH-1:0] r_q, r_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             sel_err_q, sel_err_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;

  logic [SEL_W-1:0] idx_c;
  logic [WIDTH-1:0] word_c;
  logic             set_oor_c;

  // Channel index in use this cycle: scan counter or direct select
  always_comb begin
    idx_c     = mode ? cnt_q : set;
    set_oor_c = (32'(set) >= CHANNELS);
  end

  // Word selection by decode so an illegal index never slices past in_bus
  always_comb begin
    word_c = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (idx_c == SEL_W'(k)) begin
        word_c = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: hold by default, update only on enabled cycles
  always_comb begin
    r_d       = r_q;
    ch_d      = ch_q;
    valid_d   = valid_q;
    sel_err_d = sel_err_q;
    cnt_d     = cnt_q;
    if (en) begin
      if (mode) begin
        r_d       = word_c;
        ch_d      = cnt_q;
        valid_d   = 1'b1;
        sel_err_d = 1'b0;
        cnt_d     = (cnt_q == SEL_W'(LAST_CH)) ? '0 : cnt_q + SEL_W'(1);
      end else if (set_oor_c) begin
        r_d       = '0;
        ch_d      = set;
        valid_d   = 1'b0;
        sel_err_d = 1'b1;
      end else begin
        r_d       = word_c;
        ch_d      = set;
        valid_d   = 1'b1;
        sel_err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= '0;
      ch_q      <= '0;
      valid_q   <= 1'b0;
      sel_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      r_q       <= r_d;
      ch_q      <= ch_d;
      valid_q   <= valid_d;
      sel_err_q <= sel_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign r       = r_q;
  assign ch      = ch_q;
  assign valid   = valid_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Scoreboard bench for mux_scan_reg: an 8-channel and a 6-channel instance
// share stimulus; a queue-based reference model predicts every cycle.
module tb_mux_scan_reg;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] r;
    int           ch;
    bit           valid;
    bit           err;
    int           cnt;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [8*W-1:0] in_bus8 = '0;
  logic [6*W-1:0] in_bus6;
  logic [2:0]     set = '0;
  logic           mode = 1'b0;
  logic           en = 1'b0;

  logic [W-1:0] r8, r6;
  logic [2:0]   ch8, ch6;
  logic         valid8, valid6, err8, err6;

  logic [W-1:0] data [8];
  exp_t st8, st6;
  exp_t q8[$];
  exp_t q6[$];

  int errors = 0;
  int checks = 0;

  assign in_bus6 = in_bus8[6*W-1:0];

  always #5 clk = ~clk;

  mux_scan_reg #(.WIDTH(W), .CHANNELS(8), .SEL_W(3)) dut8 (
    .clk(clk), .reset(reset), .in_bus(in_bus8), .set(set), .mode(mode), .en(en),
    .r(r8), .ch(ch8), .valid(valid8), .sel_err(err8)
  );

  mux_scan_reg #(.WIDTH(W), .CHANNELS(6), .SEL_W(3)) dut6 (
    .clk(clk), .reset(reset), .in_bus(in_bus6), .set(set), .mode(mode), .en(en),
    .r(r6), .ch(ch6), .valid(valid6), .sel_err(err6)
  );

  // Reference: outcome of one clock edge for a C-channel mux
  function automatic exp_t step(exp_t s, int c, bit rst, bit e, bit m, int sel);
    exp_t n = s;
    if (rst) begin
      n.r = '0; n.ch = 0; n.valid = 0; n.err = 0; n.cnt = 0;
    end else if (e) begin
      if (m) begin
        n.r = data[s.cnt]; n.ch = s.cnt; n.valid = 1; n.err = 0;
        n.cnt = (s.cnt + 1) % c;
      end else if (sel < c) begin
        n.r = data[sel]; n.ch = sel; n.valid = 1; n.err = 0;
      end else begin
        n.r = '0; n.ch = sel; n.valid = 0; n.err = 1;
      end
    end
    return n;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_bus();
    for (int k = 0; k < 8; k++) in_bus8[k*W +: W] = data[k];
  endtask

  // Drive one cycle and record the predicted post-edge outputs
  task automatic cyc(bit rst, bit e, bit m, int sel);
    @(negedge clk);
    reset = rst; en = e; mode = m; set = 3'(sel);
    load_bus();
    st8 = step(st8, 8, rst, e, m, sel);
    st6 = step(st6, 6, rst, e, m, sel);
    q8.push_back(st8);
    q6.push_back(st6);
  endtask

  task automatic load_plan();
    data[0] = 1; data[1] = 3; data[2] = 7;  data[3] = 4;
    data[4] = 9; data[5] = 23; data[6] = 10; data[7] = 54;
  endtask

  // Monitor: compare each predicted cycle against both instances
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check("r8", int'(r8), int'(e.r));
        check("ch8", int'(ch8), e.ch);
        check("valid8", int'(valid8), int'(e.valid));
        check("sel_err8", int'(err8), int'(e.err));
      end
      if (q6.size() > 0) begin
        e = q6.pop_front();
        check("r6", int'(r6), int'(e.r));
        check("ch6", int'(ch6), e.ch);
        check("valid6", int'(valid6), int'(e.valid));
        check("sel_err6", int'(err6), int'(e.err));
      end
    end
  end

  initial begin
    st8 = '{r: '0, ch: 0, valid: 0, err: 0, cnt: 0};
    st6 = st8;
    load_plan();

    // Reset held two cycles with en/mode active
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 5);
    // Direct select of every channel
    for (int s = 0; s < 8; s++) cyc(0, 1, 0, s);
    // Scan wrap over ten cycles
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 7);
    // Enable hold while channel 3 changes
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    data[3] = 99;
    cyc(0, 0, 0, 4);
    cyc(0, 0, 1, 6);
    cyc(0, 1, 1, 0);
    // Mode interleave: counter resumes after direct cycles
    load_plan();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 1);
    // Out-of-range selects, recovery, then scan wrap on 6 channels
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 6);
    cyc(0, 1, 0, 7);
    cyc(0, 0, 0, 2);
    cyc(0, 1, 0, 2);
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, 6);
    // Mid-scan reset restarts at channel 0
    cyc(1, 1, 1, 0);
    cyc(0, 1, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) data[$urandom_range(0, 7)] = W'($urandom);
      cyc($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
          1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue8_drained", q8.size(), 0);
    check("queue6_drained", q6.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
